// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: the MEM/WB primary write always wins, and secondary writes wait in a small FIFO.
// Latency: a primary write appears combinationally in the same cycle; a secondary write appears at least 1 cycle after it is accepted.
// Backpressure: sec_ready drops when the FIFO is full; stall_req asks for one bubble once secondary writes have starved long enough.
module wb_write_arbiter #(
  parameter  int DATA_W     = 8,
  parameter  int IDX_W      = 2,
  parameter  int QDEPTH     = 2,
  parameter  int STARVE_MAX = 4,
  localparam int CW         = $clog2(QDEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [IDX_W-1:0]  sec_idx,
  input  logic [DATA_W-1:0] sec_data,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_idx,
  output logic [DATA_W-1:0] rf_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              stall_req,
  output logic [CW-1:0]     q_count,
  output logic              err
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Queue storage. A live bit is set only for an occupied slot, so forwarding
  // does not need an occupancy check.
  logic [QDEPTH-1:0] live_q;
  logic [IDX_W-1:0]  idx_q  [QDEPTH];
  logic [DATA_W-1:0] data_q [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     starve_cnt;
  logic              err_q;

  logic push;
  logic pop;

  assign sec_ready = (cnt < CW'(QDEPTH));
  assign push      = sec_valid && sec_ready;
  assign pop       = !wb_we && (cnt != '0);
  assign q_count   = cnt;
  assign stall_req = (starve_cnt == SW'(STARVE_MAX));
  assign err       = err_q;

  // Entry state: kill older same-index entries on a primary write, retire the popped head, and write the pushed entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        idx_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (wb_we && (idx_q[i] == wb_idx)) begin
          live_q[i] <= 1'b0;
        end
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
      end
      // The push slot is never occupied, so writing it last leaves the new entry live even if a kill matched it.
      if (push) begin
        live_q[wr_ptr] <= 1'b1;
        idx_q[wr_ptr]  <= sec_idx;
        data_q[wr_ptr] <= sec_data;
      end
    end
  end

  // Pointers wrap naturally at QDEPTH (a power of two); occupancy is counted separately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Starvation tracking: count cycles where a queued write is blocked by the primary, and latch misuse of the stall request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop || (cnt == '0)) begin
        starve_cnt <= '0;
      end else if (wb_we && (starve_cnt != SW'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      if (wb_we && stall_req) begin
        err_q <= 1'b1;
      end
    end
  end

  // Write-port grant: primary first, then the FIFO head (a killed head drains with rf_we=0); held quiet during reset.
  always_comb begin
    rf_we   = 1'b0;
    rf_idx  = '0;
    rf_data = '0;
    if (rst) begin
      if (wb_we) begin
        rf_we   = 1'b1;
        rf_idx  = wb_idx;
        rf_data = wb_data;
      end else if (cnt != '0) begin
        rf_we   = live_q[rd_ptr];
        rf_idx  = idx_q[rd_ptr];
        rf_data = data_q[rd_ptr];
      end
    end
  end

  // Forwarding: walk from oldest to youngest so that the youngest live match wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot     = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      slot = rd_ptr + PW'(k);
      if (live_q[slot] && (idx_q[slot] == rd_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[slot];
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: a scoreboard of expected register-file writes plus directed status checks.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// A monitor matches every rf_we pulse against the expected-write queue, in order.
module tb_wb_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       wb_we;
  logic [1:0] wb_idx;
  logic [7:0] wb_data;
  logic       sec_valid;
  logic       sec_ready;
  logic [1:0] sec_idx;
  logic [7:0] sec_data;
  logic       rf_we;
  logic [1:0] rf_idx;
  logic [7:0] rf_data;
  logic [1:0] rd_idx;
  logic       fwd_hit;
  logic [7:0] fwd_data;
  logic       stall_req;
  logic [1:0] q_count;
  logic       err;

  int tests  = 0;
  int failed = 0;
  logic [9:0] exp_q[$];

  wb_write_arbiter #(.DATA_W(8), .IDX_W(2), .QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_idx(wb_idx), .wb_data(wb_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_idx(sec_idx), .sec_data(sec_data),
    .rf_we(rf_we), .rf_idx(rf_idx), .rf_data(rf_data),
    .rd_idx(rd_idx), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .stall_req(stall_req), .q_count(q_count), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL rf_write: unexpected write idx=%0d data=%02h, none expected", rf_idx, rf_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({rf_idx, rf_data} !== e) begin
          failed++;
          $display("FAIL rf_write: got idx=%0d data=%02h, expected idx=%0d data=%02h",
                   rf_idx, rf_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic expect_wr(input logic [1:0] i, input logic [7:0] d);
    exp_q.push_back({i, d});
  endtask

  // Drive one cycle's inputs; a primary write is always expected on the write port.
  task automatic drive(input logic we, input logic [1:0] wi, input logic [7:0] wd,
                       input logic sv, input logic [1:0] si, input logic [7:0] sd);
    wb_we = we; wb_idx = wi; wb_data = wd;
    sec_valid = sv; sec_idx = si; sec_data = sd;
    if (we) expect_wr(wi, wd);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rd_idx = 2'd0;
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    settle();
    check("reset_rf_we", rf_we, 0);
    check("reset_q_count", q_count, 0);
    check("reset_sec_ready", sec_ready, 1);
    check("reset_fwd_hit", fwd_hit, 0);
    check("reset_stall", stall_req, 0);
    check("reset_err", err, 0);
    adv(); rst = 1'b1; adv();

    // Single secondary write drains one cycle after acceptance
    drive(0, 0, 8'h00, 1, 2'd1, 8'h5A);
    settle(); check("t1_no_write_on_accept", rf_we, 0);
    adv();
    drive(0, 0, 8'h00, 0, 0, 8'h00); expect_wr(2'd1, 8'h5A);
    settle(); check("t1_q_count_1", q_count, 1);
    adv();
    settle(); check("t1_q_count_0", q_count, 0);
    adv();

    // Continuous primary writes: the queue fills, starvation builds, and the bubble drains it
    drive(1, 2'd0, 8'h10, 1, 2'd2, 8'h22);
    settle(); check("t2_ready_empty", sec_ready, 1);
    adv();
    drive(1, 2'd0, 8'h11, 1, 2'd3, 8'h33);
    settle(); adv();
    for (int c = 0; c < 3; c++) begin
      drive(1, 2'd0, 8'h12 + 8'(c), 0, 0, 8'h00);
      settle();
      check("t2_ready_full", sec_ready, 0);
      check("t2_no_stall_yet", stall_req, 0);
      adv();
    end
    drive(0, 0, 8'h00, 0, 0, 8'h00); expect_wr(2'd2, 8'h22);
    settle(); check("t2_stall_req", stall_req, 1); check("t2_q_count_2", q_count, 2);
    adv();
    expect_wr(2'd3, 8'h33);
    settle(); check("t2_stall_cleared", stall_req, 0); check("t2_q_count_after_pop", q_count, 1);
    adv();
    settle(); check("t2_drained", q_count, 0);
    adv();

    // A younger primary write to the same index kills the queued entry
    drive(0, 0, 8'h00, 1, 2'd1, 8'h11);
    adv();
    drive(1, 2'd1, 8'h22, 0, 0, 8'h00); rd_idx = 2'd1;
    settle(); check("t3_fwd_before_kill", fwd_hit, 1); check("t3_fwd_data", fwd_data, 8'h11);
    adv();
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    settle();
    check("t3_killed_pop_no_we", rf_we, 0);
    check("t3_fwd_after_kill", fwd_hit, 0);
    check("t3_slot_kept", q_count, 1);
    adv();
    settle(); check("t3_drained", q_count, 0);
    adv();

    // Two entries for the same index: forwarding picks the youngest; drain keeps the order
    drive(1, 2'd0, 8'h01, 1, 2'd3, 8'hA0); rd_idx = 2'd3;
    settle(); check("t4_enqueue_invisible", fwd_hit, 0);
    adv();
    drive(1, 2'd0, 8'h02, 1, 2'd3, 8'hB0);
    settle(); check("t4_fwd_one", fwd_hit, 1); check("t4_fwd_a0", fwd_data, 8'hA0);
    adv();
    drive(1, 2'd0, 8'h03, 0, 0, 8'h00);
    settle(); check("t4_fwd_youngest", fwd_data, 8'hB0); check("t4_q_count", q_count, 2);
    adv();
    drive(0, 0, 8'h00, 0, 0, 8'h00); expect_wr(2'd3, 8'hA0);
    settle(); adv();
    expect_wr(2'd3, 8'hB0);
    settle(); check("t4_fwd_remaining", fwd_data, 8'hB0);
    adv();
    settle(); check("t4_fwd_empty", fwd_hit, 0);
    adv();

    // Full queue, then pops with simultaneous pushes across the pointer wrap
    rd_idx = 2'd0;
    drive(1, 2'd0, 8'h04, 1, 2'd1, 8'hC1);
    adv();
    drive(1, 2'd0, 8'h05, 1, 2'd2, 8'hC2);
    adv();
    drive(0, 0, 8'h00, 1, 2'd3, 8'hC3); expect_wr(2'd1, 8'hC1);
    settle(); check("t5_full_not_ready", sec_ready, 0);
    adv();
    drive(0, 0, 8'h00, 1, 2'd3, 8'hC3); expect_wr(2'd2, 8'hC2);
    settle(); check("t5_q_one", q_count, 1);
    adv();
    drive(0, 0, 8'h00, 1, 2'd0, 8'hD4); expect_wr(2'd3, 8'hC3);
    settle(); check("t5_q_unchanged", q_count, 1);
    adv();
    drive(0, 0, 8'h00, 0, 0, 8'h00); expect_wr(2'd0, 8'hD4);
    settle(); check("t5_q_still_one", q_count, 1);
    adv();
    settle(); check("t5_drained", q_count, 0);
    adv();

    // A primary write during stall_req sets err; an asynchronous reset clears everything at once
    drive(1, 2'd0, 8'h06, 1, 2'd1, 8'hE1);
    adv();
    for (int c = 0; c < 4; c++) begin
      drive(1, 2'd0, 8'h07 + 8'(c), 0, 0, 8'h00);
      adv();
    end
    drive(1, 2'd0, 8'h0B, 0, 0, 8'h00);
    settle(); check("t6_stall_req", stall_req, 1); check("t6_err_clear", err, 0);
    adv();
    drive(1, 2'd0, 8'h0C, 1, 2'd2, 8'hF2);
    settle(); check("t6_err_set", err, 1);
    adv();
    drive(1, 2'd0, 8'h0D, 0, 0, 8'h00);
    settle(); check("t6_err_sticky", err, 1); check("t6_q_full", q_count, 2);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_q_count", q_count, 0);
    check("t6_rst_rf_we", rf_we, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_stall", stall_req, 0);
    wb_we = 1'b0; sec_valid = 1'b0;
    adv(); rst = 1'b1;
    settle(); check("t6_after_release_we", rf_we, 0); check("t6_after_release_q", q_count, 0);
    adv(); adv();

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_empty: got %0d outstanding writes, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
